// File: rtl/mvu_pkg.sv
// Shared types and helpers for the MVU input stream controller.
// Holds the controller state encoding and the width helper used for fold indices.
package mvu_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } state_e;

  // $clog2(1) is 0, but an index signal still needs at least one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mvu_inp_ctrl.sv
// Input sequencing controller for the MVU: writes the activation vector into the
// input buffer on neuron fold 0, then replays it for each remaining neuron fold.
module mvu_inp_ctrl
  import mvu_pkg::*;
#(
  parameter int SIMD    = 2,
  parameter int TSrcI   = 4,
  parameter int MatrixW = 8,
  parameter int MatrixH = 4,
  parameter int PE      = 2,
  parameter int SF      = MatrixW / SIMD,
  parameter int NF      = MatrixH / PE,
  parameter int SF_W    = clog2_min1(SF),
  parameter int NF_W    = clog2_min1(NF)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_v,
  output logic                  in_rdy,
  input  logic [SIMD*TSrcI-1:0] in_dat,
  output logic                  buf_wr_en,
  output logic [SF_W-1:0]       buf_addr,
  output logic                  out_v,
  input  logic                  out_rdy,
  output logic [SF_W-1:0]       out_sf,
  output logic [NF_W-1:0]       out_nf,
  output logic                  out_last
);

  state_e          state_q, state_d;
  logic [SF_W-1:0] sf_cnt_q, sf_cnt_d;
  logic [NF_W-1:0] nf_cnt_q, nf_cnt_d;
  logic [SF_W-1:0] addr_q, addr_d;
  logic            out_v_q, out_v_d;
  logic [SF_W-1:0] out_sf_q, out_sf_d;
  logic [NF_W-1:0] out_nf_q, out_nf_d;
  logic            out_last_q, out_last_d;

  logic adv;
  logic issue;
  logic sf_last;
  logic nf_last;

  // The data word goes straight to the buffer outside this block.
  logic unused_in_dat;
  assign unused_in_dat = ^in_dat;

  always_comb begin
    state_d    = state_q;
    sf_cnt_d   = sf_cnt_q;
    nf_cnt_d   = nf_cnt_q;
    addr_d     = addr_q;
    out_v_d    = out_v_q;
    out_sf_d   = out_sf_q;
    out_nf_d   = out_nf_q;
    out_last_d = out_last_q;

    adv     = !out_v_q || out_rdy;
    sf_last = (sf_cnt_q == SF_W'(SF - 1));
    nf_last = (nf_cnt_q == NF_W'(NF - 1));
    // Gating with resetn keeps the handshake quiet while reset is held.
    issue   = resetn && adv && ((state_q == READ) || in_v);

    if (issue) begin
      addr_d   = sf_cnt_q;
      sf_cnt_d = sf_last ? '0 : sf_cnt_q + SF_W'(1);
      if (sf_last) begin
        nf_cnt_d = nf_last ? '0 : nf_cnt_q + NF_W'(1);
      end
      if (state_q == WRITE && sf_last && NF > 1) begin
        state_d = READ;
      end else if (state_q == READ && sf_last && nf_last) begin
        state_d = WRITE;
      end
    end

    if (adv) begin
      out_v_d    = issue;
      out_sf_d   = sf_cnt_q;
      out_nf_d   = nf_cnt_q;
      out_last_d = sf_last && nf_last;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= WRITE;
      sf_cnt_q   <= '0;
      nf_cnt_q   <= '0;
      addr_q     <= '0;
      out_v_q    <= 1'b0;
      out_sf_q   <= '0;
      out_nf_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sf_cnt_q   <= sf_cnt_d;
      nf_cnt_q   <= nf_cnt_d;
      addr_q     <= addr_d;
      out_v_q    <= out_v_d;
      out_sf_q   <= out_sf_d;
      out_nf_q   <= out_nf_d;
      out_last_q <= out_last_d;
    end
  end

  // While stalled the held address is re-presented so the buffer output stays put.
  assign in_rdy    = resetn && (state_q == WRITE) && adv;
  assign buf_wr_en = issue && (state_q == WRITE);
  assign buf_addr  = issue ? sf_cnt_q : addr_q;
  assign out_v     = out_v_q;
  assign out_sf    = out_sf_q;
  assign out_nf    = out_nf_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mvu_inp_ctrl.sv
// Bench for mvu_inp_ctrl with SF=4, NF=2: directed vectors feed a scoreboard
// that a monitor drains against the output stream and a model of the input buffer.
module tb_mvu_inp_ctrl;

  localparam int SF = 4;
  localparam int NF = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       in_v = 1'b0;
  logic       in_rdy;
  logic [7:0] in_dat = 8'h00;
  logic       buf_wr_en;
  logic [1:0] buf_addr;
  logic       out_v;
  logic       out_rdy = 1'b1;
  logic [1:0] out_sf;
  logic [0:0] out_nf;
  logic       out_last;

  typedef struct packed {
    logic [1:0] sf;
    logic       nf;
    logic       last;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] mem [0:3];
  logic [7:0] dout;

  mvu_inp_ctrl #(
    .SIMD(2), .TSrcI(4), .MatrixW(8), .MatrixH(4), .PE(2)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_v      (in_v),
    .in_rdy    (in_rdy),
    .in_dat    (in_dat),
    .buf_wr_en (buf_wr_en),
    .buf_addr  (buf_addr),
    .out_v     (out_v),
    .out_rdy   (out_rdy),
    .out_sf    (out_sf),
    .out_nf    (out_nf),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  // Write-first single-port buffer with one cycle of read latency.
  always @(posedge clock) begin
    if (buf_wr_en) mem[buf_addr] <= in_dat;
    dout <= buf_wr_en ? in_dat : mem[buf_addr];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_vector(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    exp_t e;
    w = '{w0, w1, w2, w3};
    for (int nf = 0; nf < NF; nf++) begin
      for (int sf = 0; sf < SF; sf++) begin
        e.sf   = sf[1:0];
        e.nf   = nf[0];
        e.last = (sf == SF - 1) && (nf == NF - 1);
        e.dat  = w[sf];
        sb.push_back(e);
      end
    end
  endtask

  // Offers one word and returns one cycle after it is accepted.
  task automatic apply_stimulus(input logic [7:0] w);
    int n;
    n = 0;
    in_v = 1'b1;
    in_dat = w;
    @(negedge clock);
    while (!in_rdy && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!in_rdy) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: word 0x%0h got no in_rdy expected in_rdy=1", w);
    end
    @(posedge clock);
    #1;
    in_v = 1'b0;
  endtask

  always @(negedge clock) begin
    if (resetn && out_v && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out: got out_v=1 sf=%0d nf=%0d expected no output", out_sf, out_nf);
      end else begin
        mon_e = sb.pop_front();
        check_output("out_sf", 32'(out_sf), 32'(mon_e.sf));
        check_output("out_nf", 32'(out_nf), 32'(mon_e.nf));
        check_output("out_last", 32'(out_last), 32'(mon_e.last));
        check_output("dout", 32'(dout), 32'(mon_e.dat));
      end
    end
  end

  initial begin
    logic [7:0] v1 [4];
    int n;
    v1 = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset held with a word already offered.
    in_v = 1'b1;
    in_dat = v1[0];
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("rst_in_rdy", 32'(in_rdy), 0);
    check_output("rst_out_v", 32'(out_v), 0);
    check_output("rst_wr_en", 32'(buf_wr_en), 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    push_vector(8'h11, 8'h22, 8'h33, 8'h44);

    // Streaming: four writes then four replays, no gaps.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output("wr_in_rdy", 32'(in_rdy), 1);
      check_output("wr_en", 32'(buf_wr_en), 1);
      check_output("wr_addr", 32'(buf_addr), 32'(i));
      @(posedge clock);
      #1;
      if (i < 3) in_dat = v1[i+1];
      else in_v = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output("rp_wr_en", 32'(buf_wr_en), 0);
      check_output("rp_addr", 32'(buf_addr), 32'(i));
      check_output("rp_in_rdy", 32'(in_rdy), 0);
      check_output("rp_out_v", 32'(out_v), 1);
      @(posedge clock);
      #1;
    end

    // Starvation between words 2 and 3.
    push_vector(8'h55, 8'h66, 8'h77, 8'h88);
    apply_stimulus(8'h55);
    apply_stimulus(8'h66);
    @(negedge clock);
    check_output("starve_wr_en", 32'(buf_wr_en), 0);
    check_output("starve_in_rdy", 32'(in_rdy), 1);
    @(posedge clock);
    #1;
    @(negedge clock);
    check_output("bubble_out_v", 32'(out_v), 0);
    @(posedge clock);
    #1;
    apply_stimulus(8'h77);
    @(negedge clock);
    check_output("no_early_replay", 32'(in_rdy), 1);
    @(posedge clock);
    #1;
    apply_stimulus(8'h88);

    // Backpressure while the replay presents sf=2.
    n = 0;
    while (!(out_v && out_nf == 1'b1 && out_sf == 2'd2) && n < 20) begin
      n++;
      @(posedge clock);
      #1;
    end
    check_output("bp_reached", 32'(n < 20), 1);
    out_rdy = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_output("bp_addr", 32'(buf_addr), 2);
      check_output("bp_out_v", 32'(out_v), 1);
      check_output("bp_out_sf", 32'(out_sf), 2);
      check_output("bp_out_nf", 32'(out_nf), 1);
      check_output("bp_dout", 32'(dout), 32'h77);
      @(posedge clock);
      #1;
    end
    out_rdy = 1'b1;

    // Back-to-back vectors: next vector waits out the replay, then starts at addr 0.
    push_vector(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    apply_stimulus(8'hA1);
    apply_stimulus(8'hA2);
    apply_stimulus(8'hA3);
    apply_stimulus(8'hA4);
    push_vector(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    in_v = 1'b1;
    in_dat = 8'hB1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_output("b2b_wait_rdy", 32'(in_rdy), 0);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check_output("b2b_rdy", 32'(in_rdy), 1);
    check_output("b2b_wr_en", 32'(buf_wr_en), 1);
    check_output("b2b_addr", 32'(buf_addr), 0);
    @(posedge clock);
    #1;
    in_v = 1'b0;
    apply_stimulus(8'hB2);
    apply_stimulus(8'hB3);
    apply_stimulus(8'hB4);

    // Asynchronous reset in the middle of the replay.
    n = 0;
    while (!(out_v && out_nf == 1'b1 && out_sf == 2'd1) && n < 20) begin
      n++;
      @(posedge clock);
      #1;
    end
    check_output("mid_reached", 32'(n < 20), 1);
    #1;
    resetn = 1'b0;
    #1;
    check_output("async_out_v", 32'(out_v), 0);
    check_output("async_in_rdy", 32'(in_rdy), 0);
    check_output("async_wr_en", 32'(buf_wr_en), 0);
    sb.delete();
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    push_vector(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    in_v = 1'b1;
    in_dat = 8'hC1;
    @(negedge clock);
    check_output("post_rst_wr_en", 32'(buf_wr_en), 1);
    check_output("post_rst_addr", 32'(buf_addr), 0);
    @(posedge clock);
    #1;
    in_v = 1'b0;
    @(negedge clock);
    check_output("post_rst_out_v", 32'(out_v), 1);
    check_output("post_rst_sf", 32'(out_sf), 0);
    check_output("post_rst_nf", 32'(out_nf), 0);
    @(posedge clock);
    #1;
    apply_stimulus(8'hC2);
    apply_stimulus(8'hC3);
    apply_stimulus(8'hC4);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(posedge clock);
    end
    check_output("drained", 32'(sb.size()), 0);
    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
